// File: rtl/retire_queue_pkg.sv
// Shared widths, entry layout and pointer types for the in-order retire queue.
// Pointers carry one extra wrap bit above the entry index.
package retire_queue_pkg;

  localparam int unsigned VLEN       = 64;
  localparam int unsigned XLEN       = 64;
  localparam int unsigned NR_ENTRIES = 8;

  function automatic int unsigned rq_idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDW = rq_idw(NR_ENTRIES);

  typedef logic [IDW:0] ptr_t;

  typedef struct packed {
    logic            issued;
    logic            done;
    logic            ex;
    logic [VLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
  } rq_entry_t;

endpackage

// File: rtl/retire_queue_if.sv
// Issue, writeback, commit and status signals of the retire queue bundled as one port.
// slave is the queue side, master is the issue/FU/commit side.
interface retire_queue_if import retire_queue_pkg::*; #(
  parameter int unsigned NrEntries     = NR_ENTRIES,
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned NrWbPorts     = 4
) ();
  localparam int unsigned Idw = rq_idw(NrEntries);

  logic                                flush_i;
  logic                                issue_valid_i;
  logic                                issue_ready_o;
  logic [VLEN-1:0]                     issue_pc_i;
  logic [4:0]                          issue_rd_i;
  logic                                issue_ex_valid_i;
  logic [Idw-1:0]                      issue_trans_id_o;
  logic [NrWbPorts-1:0]                wb_valid_i;
  logic [NrWbPorts-1:0][Idw-1:0]       wb_trans_id_i;
  logic [NrWbPorts-1:0][XLEN-1:0]      wb_data_i;
  logic [NrWbPorts-1:0]                wb_ex_valid_i;
  logic [NrCommitPorts-1:0]            commit_valid_o;
  logic [NrCommitPorts-1:0][VLEN-1:0]  commit_pc_o;
  logic [NrCommitPorts-1:0][4:0]       commit_rd_o;
  logic [NrCommitPorts-1:0][XLEN-1:0]  commit_result_o;
  logic [NrCommitPorts-1:0]            commit_ex_valid_o;
  logic [NrCommitPorts-1:0][Idw-1:0]   commit_trans_id_o;
  logic [NrCommitPorts-1:0]            commit_ack_i;
  logic [Idw:0]                        count_o;
  logic [31:0]                         perf_full_cycles_o;

  modport slave (
    input  flush_i, issue_valid_i, issue_pc_i, issue_rd_i, issue_ex_valid_i,
    input  wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_valid_i, commit_ack_i,
    output issue_ready_o, issue_trans_id_o, commit_valid_o, commit_pc_o, commit_rd_o,
    output commit_result_o, commit_ex_valid_o, commit_trans_id_o, count_o, perf_full_cycles_o
  );

  modport master (
    output flush_i, issue_valid_i, issue_pc_i, issue_rd_i, issue_ex_valid_i,
    output wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_valid_i, commit_ack_i,
    input  issue_ready_o, issue_trans_id_o, commit_valid_o, commit_pc_o, commit_rd_o,
    input  commit_result_o, commit_ex_valid_o, commit_trans_id_o, count_o, perf_full_cycles_o
  );

endinterface

// File: rtl/retire_queue_wb_match.sv
// Selects the writeback aimed at one queue entry; when several ports target it the highest port wins.
// Purely combinational, no backpressure.
module retire_queue_wb_match import retire_queue_pkg::*; #(
  parameter int unsigned NrWbPorts = 4,
  parameter int unsigned Idw       = 3,
  parameter int unsigned EntryId   = 0
) (
  input  logic [NrWbPorts-1:0]           wb_valid_i,
  input  logic [NrWbPorts-1:0][Idw-1:0]  wb_trans_id_i,
  input  logic [NrWbPorts-1:0][XLEN-1:0] wb_data_i,
  input  logic [NrWbPorts-1:0]           wb_ex_valid_i,
  output logic                           hit_o,
  output logic [XLEN-1:0]                data_o,
  output logic                           ex_o
);

  localparam logic [Idw-1:0] MyId = Idw'(EntryId);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    ex_o   = 1'b0;
    for (int p = 0; p < int'(NrWbPorts); p++) begin
      if (wb_valid_i[p] && (wb_trans_id_i[p] == MyId)) begin
        hit_o  = 1'b1;
        data_o = wb_data_i[p];
        ex_o   = wb_ex_valid_i[p];
      end
    end
  end

endmodule

// File: rtl/retire_queue.sv
// In-order retire queue: program-order allocate, out-of-order writeback, oldest-first commit on NrCommitPorts.
// Writeback visible at commit one cycle later; issue_ready_o drops when full. RETIRE_QUEUE_PERF_EN adds a stall counter.
module retire_queue import retire_queue_pkg::*; #(
  parameter int unsigned NrEntries     = NR_ENTRIES,
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned NrWbPorts     = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  retire_queue_if.slave bus
);

  localparam int unsigned Idw   = rq_idw(NrEntries);
  localparam logic [Idw:0] Depth = (Idw+1)'(NrEntries);

  typedef logic [Idw-1:0] idx_t;
  typedef logic [Idw:0]   qptr_t;

  qptr_t     head_q, head_d, tail_q, tail_d;
  rq_entry_t entry_q [NrEntries];
  rq_entry_t entry_d [NrEntries];

  logic [NrEntries-1:0] wb_hit;
  logic [XLEN-1:0]      wb_data [NrEntries];
  logic [NrEntries-1:0] wb_ex;

  qptr_t count;
  qptr_t pop_n;
  logic  issue_ready;
  logic  alloc;
  idx_t  tail_idx;

  idx_t                               commit_idx [NrCommitPorts];
  logic [NrCommitPorts-1:0]           commit_valid;
  logic [NrCommitPorts-1:0][VLEN-1:0] commit_pc;
  logic [NrCommitPorts-1:0][4:0]      commit_rd;
  logic [NrCommitPorts-1:0][XLEN-1:0] commit_result;
  logic [NrCommitPorts-1:0]           commit_ex;
  logic [NrCommitPorts-1:0][Idw-1:0]  commit_id;
  logic                               ack_ok;

  assign count       = tail_q - head_q;
  assign issue_ready = (count < Depth);
  assign alloc       = bus.issue_valid_i && issue_ready;
  assign tail_idx    = tail_q[Idw-1:0];

  for (genvar e = 0; e < int'(NrEntries); e++) begin : g_wb
    retire_queue_wb_match #(
      .NrWbPorts (NrWbPorts),
      .Idw       (Idw),
      .EntryId   (e)
    ) u_match (
      .wb_valid_i    (bus.wb_valid_i),
      .wb_trans_id_i (bus.wb_trans_id_i),
      .wb_data_i     (bus.wb_data_i),
      .wb_ex_valid_i (bus.wb_ex_valid_i),
      .hit_o         (wb_hit[e]),
      .data_o        (wb_data[e]),
      .ex_o          (wb_ex[e])
    );
  end

  // A commit port is valid only if every older port is valid too.
  always_comb begin
    logic chain;
    chain         = 1'b1;
    commit_valid  = '0;
    commit_pc     = '0;
    commit_rd     = '0;
    commit_result = '0;
    commit_ex     = '0;
    commit_id     = '0;
    for (int k = 0; k < int'(NrCommitPorts); k++) begin
      commit_idx[k]    = head_q[Idw-1:0] + idx_t'(k);
      commit_valid[k]  = chain && entry_q[commit_idx[k]].issued && entry_q[commit_idx[k]].done;
      chain            = commit_valid[k];
      commit_pc[k]     = entry_q[commit_idx[k]].pc;
      commit_rd[k]     = entry_q[commit_idx[k]].rd;
      commit_result[k] = entry_q[commit_idx[k]].result;
      commit_ex[k]     = entry_q[commit_idx[k]].ex;
      commit_id[k]     = commit_idx[k];
    end
  end

  always_comb begin
    logic prev;
    prev   = 1'b1;
    ack_ok = 1'b1;
    for (int k = 0; k < int'(NrCommitPorts); k++) begin
      if (bus.commit_ack_i[k] && (!prev || !commit_valid[k])) ack_ok = 1'b0;
      prev = bus.commit_ack_i[k];
    end
  end

  // Order matters: writeback, then pop, then allocate, with flush overriding all of them.
  always_comb begin
    for (int e = 0; e < int'(NrEntries); e++) entry_d[e] = entry_q[e];
    head_d = head_q;
    tail_d = tail_q;
    pop_n  = '0;

    for (int e = 0; e < int'(NrEntries); e++) begin
      if (wb_hit[e] && entry_q[e].issued) begin
        entry_d[e].result = wb_data[e];
        entry_d[e].done   = 1'b1;
        entry_d[e].ex     = entry_q[e].ex | wb_ex[e];
      end
    end

    for (int k = 0; k < int'(NrCommitPorts); k++) begin
      if (bus.commit_ack_i[k]) begin
        entry_d[commit_idx[k]].issued = 1'b0;
        entry_d[commit_idx[k]].done   = 1'b0;
        pop_n = pop_n + qptr_t'(1);
      end
    end
    head_d = head_q + pop_n;

    if (alloc) begin
      entry_d[tail_idx].issued = 1'b1;
      entry_d[tail_idx].done   = bus.issue_ex_valid_i;
      entry_d[tail_idx].ex     = bus.issue_ex_valid_i;
      entry_d[tail_idx].pc     = bus.issue_pc_i;
      entry_d[tail_idx].rd     = bus.issue_rd_i;
      tail_d = tail_q + qptr_t'(1);
    end

    if (bus.flush_i) begin
      head_d = '0;
      tail_d = '0;
      for (int e = 0; e < int'(NrEntries); e++) begin
        entry_d[e].issued = 1'b0;
        entry_d[e].done   = 1'b0;
        entry_d[e].ex     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      for (int e = 0; e < int'(NrEntries); e++) begin
        entry_q[e].issued <= 1'b0;
        entry_q[e].done   <= 1'b0;
        entry_q[e].ex     <= 1'b0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int e = 0; e < int'(NrEntries); e++) entry_q[e] <= entry_d[e];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !bus.flush_i) assert (ack_ok);
  end

  assign bus.issue_ready_o     = issue_ready;
  assign bus.issue_trans_id_o  = tail_idx;
  assign bus.commit_valid_o    = commit_valid;
  assign bus.commit_pc_o       = commit_pc;
  assign bus.commit_rd_o       = commit_rd;
  assign bus.commit_result_o   = commit_result;
  assign bus.commit_ex_valid_o = commit_ex;
  assign bus.commit_trans_id_o = commit_id;
  assign bus.count_o           = count;

`ifdef RETIRE_QUEUE_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (bus.issue_valid_i && !issue_ready && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign bus.perf_full_cycles_o = perf_q;
`else
  assign bus.perf_full_cycles_o = '0;
`endif

endmodule

// File: tb/tb_retire_queue.sv
// Directed bench for retire_queue: reset, fill, full+ack, out-of-order writeback, port priority, wrap, flush.
module tb_retire_queue;
  import retire_queue_pkg::*;

  localparam int unsigned NE = 8;
  localparam int unsigned NC = 2;
  localparam int unsigned NW = 4;

`ifdef RETIRE_QUEUE_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  retire_queue_if #(.NrEntries(NE), .NrCommitPorts(NC), .NrWbPorts(NW)) bus ();

  retire_queue #(.NrEntries(NE), .NrCommitPorts(NC), .NrWbPorts(NW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_i          = 1'b0;
    bus.issue_valid_i    = 1'b0;
    bus.issue_pc_i       = '0;
    bus.issue_rd_i       = '0;
    bus.issue_ex_valid_i = 1'b0;
    bus.wb_valid_i       = '0;
    bus.wb_trans_id_i    = '0;
    bus.wb_data_i        = '0;
    bus.wb_ex_valid_i    = '0;
    bus.commit_ack_i     = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [63:0] pc, input logic [4:0] rd, input logic ex);
    bus.issue_valid_i    = 1'b1;
    bus.issue_pc_i       = pc;
    bus.issue_rd_i       = rd;
    bus.issue_ex_valid_i = ex;
    step();
    bus.issue_valid_i    = 1'b0;
    bus.issue_ex_valid_i = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [2:0] id, input logic [63:0] d, input logic ex);
    bus.wb_valid_i[p]    = 1'b1;
    bus.wb_trans_id_i[p] = id;
    bus.wb_data_i[p]     = d;
    bus.wb_ex_valid_i[p] = ex;
  endtask

  task automatic test_reset();
    idle();
    bus.issue_valid_i = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.issue_ready_o); end
    checks++; if (bus.issue_trans_id_o !== 3'd0) begin errors++; $display("FAIL rst_id got %0d exp 0", bus.issue_trans_id_o); end
    checks++; if (bus.commit_valid_o !== 2'b00) begin errors++; $display("FAIL rst_cvalid got %b exp 00", bus.commit_valid_o); end
    checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.count_o); end
    checks++; if (bus.perf_full_cycles_o !== 32'd0) begin errors++; $display("FAIL rst_perf got %0d exp 0", bus.perf_full_cycles_o); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b exp 1", i, bus.issue_ready_o); end
      issue(64'h100 + 64'(4 * i), 5'(i), 1'b0);
    end
    checks++; if (bus.issue_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", bus.issue_ready_o); end
    checks++; if (bus.count_o !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", bus.count_o); end
    checks++; if (bus.commit_valid_o !== 2'b00) begin errors++; $display("FAIL fill_cvalid got %b exp 00", bus.commit_valid_o); end
    bus.issue_valid_i = 1'b1;
    bus.issue_pc_i    = 64'hDEAD;
    step(); step(); step();
    idle();
    checks++; if (bus.count_o !== 4'd8) begin errors++; $display("FAIL fill_hold_count got %0d exp 8", bus.count_o); end
    checks++; if (bus.perf_full_cycles_o !== (PerfOn ? 32'd3 : 32'd0)) begin errors++; $display("FAIL fill_perf got %0d exp %0d", bus.perf_full_cycles_o, PerfOn ? 3 : 0); end
  endtask

  // Runs on the full queue left by test_fill.
  task automatic test_full_ack();
    set_wb(0, 3'd0, 64'h55, 1'b0);
    step();
    idle();
    checks++; if (bus.commit_valid_o !== 2'b01) begin errors++; $display("FAIL fa_cvalid got %b exp 01", bus.commit_valid_o); end
    checks++; if (bus.commit_pc_o[0] !== 64'h100) begin errors++; $display("FAIL fa_pc got %h exp 100", bus.commit_pc_o[0]); end
    bus.commit_ack_i  = 2'b01;
    bus.issue_valid_i = 1'b1;
    bus.issue_pc_i    = 64'h500;
    step();
    bus.commit_ack_i  = 2'b00;
    checks++; if (bus.count_o !== 4'd7) begin errors++; $display("FAIL fa_count_ack got %0d exp 7", bus.count_o); end
    checks++; if (bus.issue_ready_o !== 1'b1) begin errors++; $display("FAIL fa_ready got %b exp 1", bus.issue_ready_o); end
    checks++; if (bus.issue_trans_id_o !== 3'd0) begin errors++; $display("FAIL fa_id got %0d exp 0", bus.issue_trans_id_o); end
    checks++; if (bus.commit_trans_id_o[0] !== 3'd1) begin errors++; $display("FAIL fa_head got %0d exp 1", bus.commit_trans_id_o[0]); end
    step();
    idle();
    checks++; if (bus.count_o !== 4'd8) begin errors++; $display("FAIL fa_count_refill got %0d exp 8", bus.count_o); end
    checks++; if (bus.issue_ready_o !== 1'b0) begin errors++; $display("FAIL fa_ready_refill got %b exp 0", bus.issue_ready_o); end
    checks++; if (bus.perf_full_cycles_o !== (PerfOn ? 32'd4 : 32'd0)) begin errors++; $display("FAIL fa_perf got %0d exp %0d", bus.perf_full_cycles_o, PerfOn ? 4 : 0); end
  endtask

  task automatic test_ooo_wb();
    do_reset();
    issue(64'h200, 5'd1, 1'b0);
    issue(64'h204, 5'd2, 1'b0);
    set_wb(1, 3'd1, 64'h11, 1'b0);
    step();
    idle();
    checks++; if (bus.commit_valid_o !== 2'b00) begin errors++; $display("FAIL ooo_cvalid_first got %b exp 00", bus.commit_valid_o); end
    set_wb(0, 3'd0, 64'h10, 1'b0);
    step();
    idle();
    checks++; if (bus.commit_valid_o !== 2'b11) begin errors++; $display("FAIL ooo_cvalid got %b exp 11", bus.commit_valid_o); end
    checks++; if (bus.commit_result_o[0] !== 64'h10) begin errors++; $display("FAIL ooo_res0 got %h exp 10", bus.commit_result_o[0]); end
    checks++; if (bus.commit_result_o[1] !== 64'h11) begin errors++; $display("FAIL ooo_res1 got %h exp 11", bus.commit_result_o[1]); end
    checks++; if (bus.commit_pc_o[1] !== 64'h204) begin errors++; $display("FAIL ooo_pc1 got %h exp 204", bus.commit_pc_o[1]); end
    checks++; if (bus.commit_rd_o[0] !== 5'd1) begin errors++; $display("FAIL ooo_rd0 got %0d exp 1", bus.commit_rd_o[0]); end
    checks++; if (bus.commit_trans_id_o[1] !== 3'd1) begin errors++; $display("FAIL ooo_id1 got %0d exp 1", bus.commit_trans_id_o[1]); end
    bus.commit_ack_i = 2'b11;
    step();
    idle();
    checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL ooo_count got %0d exp 0", bus.count_o); end
    checks++; if (bus.commit_trans_id_o[0] !== 3'd2) begin errors++; $display("FAIL ooo_head got %0d exp 2", bus.commit_trans_id_o[0]); end
    set_wb(0, 3'd2, 64'h77, 1'b0);
    issue(64'h208, 5'd3, 1'b0);
    idle();
    checks++; if (bus.count_o !== 4'd1) begin errors++; $display("FAIL ooo_samecyc_count got %0d exp 1", bus.count_o); end
    checks++; if (bus.commit_valid_o !== 2'b00) begin errors++; $display("FAIL ooo_samecyc_wb got %b exp 00", bus.commit_valid_o); end
  endtask

  task automatic test_wb_priority();
    do_reset();
    for (int i = 0; i < 4; i++) issue(64'h300 + 64'(4 * i), 5'(i), 1'b0);
    set_wb(1, 3'd0, 64'h01, 1'b0);
    set_wb(3, 3'd1, 64'h02, 1'b0);
    set_wb(0, 3'd3, 64'hAA, 1'b0);
    set_wb(2, 3'd3, 64'hBB, 1'b1);
    step();
    idle();
    checks++; if (bus.commit_valid_o !== 2'b11) begin errors++; $display("FAIL pri_cvalid got %b exp 11", bus.commit_valid_o); end
    bus.commit_ack_i = 2'b11;
    step();
    idle();
    checks++; if (bus.commit_valid_o !== 2'b00) begin errors++; $display("FAIL pri_cvalid_gap got %b exp 00", bus.commit_valid_o); end
    set_wb(0, 3'd2, 64'h22, 1'b0);
    issue(64'h400, 5'd5, 1'b1);
    idle();
    checks++; if (bus.commit_valid_o !== 2'b11) begin errors++; $display("FAIL pri_cvalid2 got %b exp 11", bus.commit_valid_o); end
    checks++; if (bus.commit_result_o[0] !== 64'h22) begin errors++; $display("FAIL pri_res2 got %h exp 22", bus.commit_result_o[0]); end
    checks++; if (bus.commit_result_o[1] !== 64'hBB) begin errors++; $display("FAIL pri_res3 got %h exp BB", bus.commit_result_o[1]); end
    checks++; if (bus.commit_ex_valid_o !== 2'b10) begin errors++; $display("FAIL pri_ex got %b exp 10", bus.commit_ex_valid_o); end
    bus.commit_ack_i = 2'b11;
    step();
    idle();
    checks++; if (bus.commit_valid_o !== 2'b01) begin errors++; $display("FAIL pri_issue_ex_valid got %b exp 01", bus.commit_valid_o); end
    checks++; if (bus.commit_ex_valid_o[0] !== 1'b1) begin errors++; $display("FAIL pri_issue_ex got %b exp 1", bus.commit_ex_valid_o[0]); end
    checks++; if (bus.commit_pc_o[0] !== 64'h400) begin errors++; $display("FAIL pri_issue_pc got %h exp 400", bus.commit_pc_o[0]); end
    bus.commit_ack_i = 2'b01;
    step();
    idle();
    checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL pri_count got %0d exp 0", bus.count_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(64'h600, 5'd1, 1'b0);
    issue(64'h604, 5'd2, 1'b0);
    set_wb(0, 3'd0, 64'hA0, 1'b0);
    set_wb(1, 3'd1, 64'hA1, 1'b0);
    step();
    idle();
    bus.commit_ack_i = 2'b01;
    issue(64'h608, 5'd3, 1'b0);
    idle();
    checks++; if (bus.count_o !== 4'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", bus.count_o); end
    checks++; if (bus.commit_valid_o !== 2'b01) begin errors++; $display("FAIL b2b_cvalid got %b exp 01", bus.commit_valid_o); end
    checks++; if (bus.commit_trans_id_o[0] !== 3'd1) begin errors++; $display("FAIL b2b_head got %0d exp 1", bus.commit_trans_id_o[0]); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      checks++; if (bus.issue_trans_id_o !== 3'(i % 8)) begin errors++; $display("FAIL wrap_id_%0d got %0d exp %0d", i, bus.issue_trans_id_o, i % 8); end
      issue(64'h1000 + 64'(4 * i), 5'(i), 1'b0);
      set_wb(0, 3'(i % 8), 64'(i), 1'b0);
      step();
      idle();
      checks++; if (bus.commit_pc_o[0] !== 64'h1000 + 64'(4 * i) || bus.commit_valid_o !== 2'b01) begin
        errors++; $display("FAIL wrap_commit_%0d got pc %h v %b exp pc %h v 01", i, bus.commit_pc_o[0], bus.commit_valid_o, 64'h1000 + 64'(4 * i));
      end
      bus.commit_ack_i = 2'b01;
      step();
      bus.commit_ack_i = 2'b00;
    end
    checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", bus.count_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) issue(64'h2000 + 64'(4 * i), 5'(i), 1'b0);
    bus.flush_i       = 1'b1;
    bus.issue_valid_i = 1'b1;
    bus.issue_pc_i    = 64'h2FFF;
    set_wb(0, 3'd0, 64'hFF, 1'b0);
    step();
    idle();
    checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL fl_count got %0d exp 0", bus.count_o); end
    checks++; if (bus.commit_valid_o !== 2'b00) begin errors++; $display("FAIL fl_cvalid got %b exp 00", bus.commit_valid_o); end
    checks++; if (bus.issue_trans_id_o !== 3'd0) begin errors++; $display("FAIL fl_id got %0d exp 0", bus.issue_trans_id_o); end
    issue(64'h3000, 5'd4, 1'b0);
    checks++; if (bus.count_o !== 4'd1) begin errors++; $display("FAIL fl_reissue_count got %0d exp 1", bus.count_o); end
    checks++; if (bus.commit_valid_o !== 2'b00) begin errors++; $display("FAIL fl_reissue_cvalid got %b exp 00", bus.commit_valid_o); end
    checks++; if (bus.commit_pc_o[0] !== 64'h3000) begin errors++; $display("FAIL fl_reissue_pc got %h exp 3000", bus.commit_pc_o[0]); end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_full_ack();
    test_ooo_wb();
    test_wb_priority();
    test_back_to_back();
    test_wrap();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
